// File: rtl/ap_unsi_wall_pipe.sv
// Unsigned DW x DW multiplier: Wallace carry-save reduction, 2-stage valid/ready pipeline.
// Optional macro AP_COMP_EN adds 2^(APR-1) bias compensation to approximate results.
module ap_unsi_wall_pipe #(
  parameter int DW  = 12,
  parameter int APR = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DW-1:0]     muld,
  input  logic [DW-1:0]     mulr,
  input  logic              exact,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [2*DW-1:0]   res,
  output logic              out_apx
);

  localparam int PW = 2 * DW;

`ifdef AP_COMP_EN
  localparam logic [PW-1:0] COMP = (APR > 0) ? (PW'(1) << ((APR > 0) ? APR - 1 : 0)) : '0;
`endif

  logic [PW-1:0] rw  [DW];
  logic [PW-1:0] tmp [DW];
  logic [DW-1:0] row;
  logic [PW-1:0] csa_a, csa_b, csa_c;
  logic [PW-1:0] red_sum, red_car;
  int            n, m, rest;

  logic [PW-1:0] s1_sum, s1_car;
  logic          s1_vld, s1_apx;
  logic          s1_adv, s2_adv;
  logic [PW-1:0] fin_sum;

  // Partial-product rows (low columns masked in approximate mode), then
  // layered 3:2 reduction until two rows remain. Carries out of the top
  // column are dropped: the true product always fits in PW bits.
  always_comb begin
    row   = '0;
    csa_a = '0;
    csa_b = '0;
    csa_c = '0;
    n     = DW;
    m     = 0;
    rest  = 0;
    for (int i = 0; i < DW; i++) begin
      row = '0;
      for (int j = 0; j < DW; j++) begin
        if (exact || (i + j >= APR)) row[j] = muld[j] & mulr[i];
      end
      rw[i] = {{DW{1'b0}}, row} << i;
    end
    for (int lvl = 0; lvl < DW; lvl++) begin
      for (int k = 0; k < DW; k++) tmp[k] = '0;
      if (n > 2) begin
        m = 0;
        for (int g = 0; g < DW / 3 + 1; g++) begin
          if (3 * g + 2 < n) begin
            csa_a      = rw[3 * g];
            csa_b      = rw[3 * g + 1];
            csa_c      = rw[3 * g + 2];
            tmp[m]     = csa_a ^ csa_b ^ csa_c;
            tmp[m + 1] = ((csa_a & csa_b) | (csa_a & csa_c) | (csa_b & csa_c)) << 1;
            m          = m + 2;
          end
        end
        rest = n - 3 * (n / 3);
        for (int r = 0; r < 2; r++) begin
          if (r < rest) tmp[m + r] = rw[3 * (n / 3) + r];
        end
        n = m + rest;
        for (int k = 0; k < DW; k++) rw[k] = tmp[k];
      end
    end
    red_sum = rw[0];
    red_car = rw[1];
  end

  assign s2_adv = ~out_vld | out_rdy;
  assign s1_adv = ~s1_vld | s2_adv;
  assign in_rdy = rst | s1_adv;

  always_comb begin
    fin_sum = s1_sum + s1_car;
`ifdef AP_COMP_EN
    if (s1_apx) fin_sum = fin_sum + COMP;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_sum <= red_sum;
        s1_car <= red_car;
        s1_apx <= ~exact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_apx <= 1'b0;
      res     <= '0;
    end else if (s2_adv) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        res     <= fin_sum;
        out_apx <= s1_apx;
      end
    end
  end

endmodule

// File: tb/tb_ap_unsi_wall_pipe.sv
// Self-checking bench for ap_unsi_wall_pipe (DW=12, APR=12): arithmetic reference
// model with an in-order expected-result queue, plus directed literal checks.
module tb_ap_unsi_wall_pipe;
  localparam int DW  = 12;
  localparam int APR = 12;
  localparam int PW  = 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] muld = '0;
  logic [DW-1:0] mulr = '0;
  logic          exact = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [PW-1:0] res;
  logic          out_apx;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [PW-1:0] expq[$];
  bit            apxq[$];
  bit            prev_stall = 0;
  logic [PW-1:0] prev_res;
  logic          prev_apx;

  ap_unsi_wall_pipe #(.DW(DW), .APR(APR)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .muld(muld), .mulr(mulr), .exact(exact),
    .out_vld(out_vld), .out_rdy(out_rdy), .res(res), .out_apx(out_apx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Approximate product: each multiplier bit i contributes muld shifted by i,
  // with the muld bits that would land below column APR cleared.
  function automatic logic [PW-1:0] model(input longint unsigned a, input longint unsigned b,
                                          input bit ex);
    longint unsigned acc;
    longint unsigned keep;
    int lo;
    if (ex) return PW'(a * b);
    acc = 0;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) begin
        lo   = APR - i;
        keep = (lo > 0) ? (a & ~((64'd1 << lo) - 1)) : a;
        acc  = acc + (keep << i);
      end
    end
`ifdef AP_COMP_EN
    if (APR > 0) acc = acc + (64'd1 << (APR - 1));
`endif
    return PW'(acc);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      apxq.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", out_vld, 1);
        chk("stall_res", res, prev_res);
        chk("stall_apx", out_apx, prev_apx);
      end
      if (out_vld && out_rdy) begin
        n_out++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got res %0d with no pending transaction at %0t", res, $time);
        end else begin
          chk("res", res, expq.pop_front());
          chk("out_apx", out_apx, apxq.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        expq.push_back(model(muld, mulr, exact));
        apxq.push_back(!exact);
      end
      prev_stall = out_vld && !out_rdy;
      prev_res   = res;
      prev_apx   = out_apx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { int a; int b; bit ex; } vec_t;
  vec_t vecs[8] = '{
    '{4095, 4095, 1'b1}, '{4095, 1, 1'b0}, '{64, 64, 1'b0}, '{2048, 2, 1'b0},
    '{0, 4095, 1'b0},    '{1, 4095, 1'b1}, '{4095, 4095, 1'b0}, '{1234, 3210, 1'b0}
  };

  int acc_cnt;
  int outs_before;
  int waitc;

  initial begin
    // Model pins
    chk("pin_exact_max", model(4095, 4095, 1), 16769025);
`ifdef AP_COMP_EN
    chk("pin_trunc_low", model(4095, 1, 0), 2048);
    chk("pin_64x64", model(64, 64, 0), 6144);
`else
    chk("pin_trunc_low", model(4095, 1, 0), 0);
    chk("pin_64x64", model(64, 64, 0), 4096);
`endif

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_out_apx", out_apx, 0);
    chk("rst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: accepted in one cycle, valid two cycles later
    in_vld = 1'b1; muld = 4095; mulr = 4095; exact = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    chk("lat_in_rdy", in_rdy, 1);
    tick();
    in_vld = 1'b0;
    @(negedge clk);
    chk("lat_vld_c1", out_vld, 0);
    @(negedge clk);
    chk("lat_vld_c2", out_vld, 1);
    chk("lat_res", res, 16769025);
    chk("lat_apx", out_apx, 0);
    tick();

    // Back-to-back directed vectors at full throughput
    foreach (vecs[k]) begin
      in_vld = 1'b1; muld = DW'(vecs[k].a); mulr = DW'(vecs[k].b); exact = vecs[k].ex;
      @(negedge clk);
      chk("thru_in_rdy", in_rdy, 1);
      tick();
    end
    in_vld = 1'b0;
    repeat (4) tick();
    chk("thru_drained", expq.size(), 0);

    // Stall: three offers with out_rdy low, only two fit
    out_rdy = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      in_vld = 1'b1; muld = DW'(100 + k); mulr = DW'(300 + 7 * k); exact = (k != 1);
      @(negedge clk);
      if (k == 2) chk("full_in_rdy", in_rdy, 0);
      if (in_rdy) acc_cnt++;
      tick();
    end
    in_vld = 1'b0;
    chk("stall_accepted", acc_cnt, 2);
    repeat (3) tick();
    out_rdy = 1'b1;
    repeat (4) tick();
    chk("stall_drained", expq.size(), 0);

    // Reset with two transactions in flight
    out_rdy = 1'b0;
    in_vld = 1'b1; muld = 555; mulr = 777; exact = 1'b1;
    tick();
    muld = 4000; mulr = 3999; exact = 1'b0;
    tick();
    in_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_res", res, 0);
    chk("midrst_in_rdy", in_rdy, 1);
    outs_before = n_out;
    out_rdy = 1'b1;
    repeat (5) tick();
    chk("midrst_no_ghost", n_out, outs_before);

    // Random operands, modes and backpressure
    for (int c = 0; c < 400; c++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: muld = '1;
        1: muld = '0;
        default: muld = DW'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: mulr = '1;
        1: mulr = DW'(1);
        default: mulr = DW'($urandom);
      endcase
      exact   = $urandom_range(0, 1) != 0;
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    waitc = 0;
    while (expq.size() != 0 && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("rand_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_unsi_wall_pipe.md
AP_UNSI_WALL_PIPE -- requirements
Module: ap_unsi_wall_pipe

Interface
REQ-001 Parameter: DW, default 12, operand width in bits; legal range 4..32.
REQ-002 Parameter: APR, default 12, count of low product columns removed in approximate mode; legal range 0..DW.
REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port: rst, input, 1; reset is synchronous and active-high.
REQ-005 Port: in_vld, input, 1, operand pair valid.
REQ-006 Port: in_rdy, output, 1, block accepts operands this cycle.
REQ-007 Port: muld, input, DW, unsigned multiplicand.
REQ-008 Port: mulr, input, DW, unsigned multiplier.
REQ-009 Port: exact, input, 1, per-transaction mode: 1 = exact product, 0 = approximate.
REQ-010 Port: out_vld, output, 1, result valid.
REQ-011 Port: out_rdy, input, 1, downstream accepts the result.
REQ-012 Port: res, output, 2*DW, unsigned product.
REQ-013 Port: out_apx, output, 1, res was produced in approximate mode.

Function
REQ-014 Partial products: pp[i][j] = muld[j] & mulr[i], with column weight i+j.
REQ-015 Exact mode: res = muld*mulr, bit-exact, in full 2*DW width.
REQ-016 Approximate mode: every pp bit with i+j < APR is forced to 0 before reduction.
REQ-017 Approximate mode: the remaining pp bits are summed exactly.
REQ-018 APR=0: approximate result equals exact result.
REQ-019 The result never overflows 2*DW bits, including the compensation term of REQ-034; no saturation logic is present.
REQ-020 Pipeline stage S1 registers the Wallace-reduced carry-save pair (sum and carry vectors), the mode bit and a valid bit.
REQ-021 Pipeline stage S2 registers the final carry-propagate sum, out_apx and out_vld.
REQ-022 Latency: an accepted operand pair appears on res/out_vld exactly 2 cycles after acceptance when out_rdy is held high.
REQ-023 Throughput: one transaction per cycle when out_rdy is held high.
REQ-024 Handshake: a transfer occurs when vld and rdy are both high on a rising edge, on input and on output.
REQ-025 S2 advance condition: s2_adv = ~out_vld | out_rdy.
REQ-026 S1 advance condition: s1_adv = ~s1_vld | s2_adv.
REQ-027 in_rdy = s1_adv; in_rdy has a combinational path from out_rdy.
REQ-028 Stall: while out_vld=1 and out_rdy=0, res and out_apx remain stable, out_vld stays 1 and no data is lost.
REQ-029 Full: with both stages occupied and out_rdy=0, in_rdy=0 and input operands are ignored.
REQ-030 Simultaneous events: an input transfer and an output transfer in the same cycle both complete; occupancy is unchanged.
REQ-031 Bubbles: when no input transfer occurs into a stage, that stage's valid bit clears as its content moves on; data registers may hold stale values.

Reset
REQ-032 On rst=1 at a clock edge: s1_vld=0, out_vld=0, out_apx=0, res=0; while rst=1, in_rdy=1.
REQ-033 Reset mid-operation discards all in-flight transactions; the first cycle after reset deasserts behaves as empty.

Configuration
REQ-034 AP_COMP_EN defined: approximate results with APR>0 have the constant 2^(APR-1) added (bias compensation); exact results are unaffected.
REQ-035 AP_COMP_EN undefined: approximate results are pure truncation with no constant added; no compensation logic is present.

Verification (DW=12, APR=12)
REQ-036 Scenario: muld=4095, mulr=4095, exact=1 -> res=16769025, out_apx=0, out_vld 2 cycles after acceptance.
REQ-037 Scenario: muld=4095, mulr=1, exact=0 -> res=0 without AP_COMP_EN, 2048 with it; out_apx=1.
REQ-038 Scenario: muld=64, mulr=64, exact=0, without AP_COMP_EN -> res=4096 (equals exact).
REQ-039 Scenario: 3 back-to-back inputs with out_rdy=0 -> 2 accepted; in_rdy=0 on the 3rd; raise out_rdy -> results emerge in order with res stable during the stall.
REQ-040 Scenario: pulse rst while 2 transactions are in flight -> out_vld=0 and res=0 on the next cycle; neither transaction ever appears.
REQ-041 Scenario: random operands, mixed modes, random out_rdy -> every result matches the reference model, in order, with no loss or duplication.
